// File: rtl/enc_serial_pri.sv
// Serial priority encoder: accepts a request vector over valid/ready and emits
// the index of each set bit, one per output handshake, lowest- or highest-first.
module enc_serial_pri #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(WIDTH)-1:0]     out_idx,
    output logic                         out_last,
    output logic [$clog2(WIDTH):0]       count,
    output logic                         empty
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               empty_q, empty_d;

    logic [IDX_W-1:0]   sel_idx;
    logic               one_left;
    logic [IDX_W:0]     in_pop;

    // Later matches overwrite earlier ones, so scan direction sets the priority.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (pending_q[i-1]) sel_idx = IDX_W'(i - 1);
            end
        end
    end

    always_comb begin
        in_pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            in_pop = in_pop + (IDX_W+1)'(in_data[i]);
        end
    end

    assign one_left = (pending_q != '0) &&
                      ((pending_q & (pending_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        empty_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    count_d = in_pop;
                    if (in_data != '0) begin
                        pending_d = in_data;
                        state_d   = EMIT;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << sel_idx);
                    if (one_left) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
        end
    end

    // pending_q is zero whenever IDLE, so out_idx decodes to 0 outside EMIT.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = (state_q == EMIT) && one_left;
    assign count     = count_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_enc_serial_pri.sv
// Scoreboard bench for enc_serial_pri: three instances (8-bit LSB-first,
// 8-bit MSB-first, 16-bit LSB-first) driven with directed vectors.
module tb_enc_serial_pri;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ordy [3];
    logic [15:0] idata[3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ol   [3];
    logic        emp  [3];
    logic [3:0]  oidx [3];
    logic [4:0]  cnt  [3];

    logic [2:0]  idx_a, idx_b;
    logic [3:0]  idx_c;
    logic [3:0]  cnt_a, cnt_b;
    logic [4:0]  cnt_c;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [3][$];   // entries encode idx*2 + last

    enc_serial_pri #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0][7:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(idx_a), .out_last(ol[0]),
        .count(cnt_a), .empty(emp[0]));

    enc_serial_pri #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1][7:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(idx_b), .out_last(ol[1]),
        .count(cnt_b), .empty(emp[1]));

    enc_serial_pri #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idata[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(idx_c), .out_last(ol[2]),
        .count(cnt_c), .empty(emp[2]));

    assign oidx[0] = {1'b0, idx_a};
    assign oidx[1] = {1'b0, idx_b};
    assign oidx[2] = idx_c;
    assign cnt[0]  = {1'b0, cnt_a};
    assign cnt[1]  = {1'b0, cnt_b};
    assign cnt[2]  = cnt_c;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every valid beat is compared with the queue head; popped on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("unexpected_beat_dut%0d", d), oidx[d], -1);
                end else begin
                    chk($sformatf("beat_dut%0d", d), oidx[d] * 2 + int'(ol[d]), exp_q[d][0]);
                    if (ordy[d]) void'(exp_q[d].pop_front());
                end
            end
        end
    end

    task automatic push(input int d, input int idx, input bit last);
        exp_q[d].push_back(idx * 2 + int'(last));
    endtask

    task automatic accept(input int d, input logic [15:0] data);
        int t = 0;
        while (!ir[d] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk($sformatf("in_ready_wait_dut%0d", d), int'(ir[d]), 1);
        iv[d]    = 1'b1;
        idata[d] = data;
        @(posedge clk); #1;
        iv[d]    = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while ((exp_q[d].size() != 0 || ov[d]) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk($sformatf("drain_dut%0d", d), exp_q[d].size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; idata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready",  int'(ir[d]),  1);
            chk("rst_out_valid", int'(ov[d]),  0);
            chk("rst_out_idx",   oidx[d],      0);
            chk("rst_out_last",  int'(ol[d]),  0);
            chk("rst_count",     cnt[d],       0);
            chk("rst_empty",     int'(emp[d]), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Single low bit: one beat, ready again two cycles after accept.
        push(0, 0, 1'b1);
        accept(0, 16'h0001);
        chk("t1_out_valid", int'(ov[0]), 1);
        chk("t1_in_ready_busy", int'(ir[0]), 0);
        chk("t1_count", cnt[0], 1);
        @(posedge clk); #1;
        chk("t1_in_ready_back", int'(ir[0]), 1);
        chk("t1_out_valid_off", int'(ov[0]), 0);

        // 8'b10010110 back to back: 4 EMIT cycles then IDLE.
        push(0, 1, 1'b0); push(0, 2, 1'b0); push(0, 4, 1'b0); push(0, 7, 1'b1);
        accept(0, 16'h0096);
        chk("t2_count", cnt[0], 4);
        repeat (4) @(posedge clk);
        #1;
        chk("t2_in_ready_after_4", int'(ir[0]), 1);
        chk("t2_queue_empty", exp_q[0].size(), 0);

        // Same vector with back-pressure at beat 2.
        push(0, 1, 1'b0); push(0, 2, 1'b0); push(0, 4, 1'b0); push(0, 7, 1'b1);
        accept(0, 16'h0096);
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_held_idx", oidx[0], 2);
        chk("t3_held_last", int'(ol[0]), 0);
        ordy[0] = 1'b1;
        drain(0);

        // All-zero vector: single empty pulse, no output.
        accept(0, 16'h0000);
        chk("t4_empty_pulse", int'(emp[0]), 1);
        chk("t4_out_valid", int'(ov[0]), 0);
        chk("t4_count", cnt[0], 0);
        chk("t4_in_ready", int'(ir[0]), 1);
        @(posedge clk); #1;
        chk("t4_empty_clear", int'(emp[0]), 0);
        chk("t4_count_hold", cnt[0], 0);

        // MSB-first ordering.
        push(1, 7, 1'b0); push(1, 4, 1'b0); push(1, 2, 1'b0); push(1, 1, 1'b1);
        accept(1, 16'h0096);
        chk("t5_msb_count", cnt[1], 4);
        drain(1);

        // 16-bit all ones.
        for (int i = 0; i < 16; i++) push(2, i, i == 15);
        accept(2, 16'hFFFF);
        chk("t5_w16_count", cnt[2], 16);
        drain(2);
        chk("t5_w16_count_hold", cnt[2], 16);

        // Reset mid-EMIT after two beats of 8'hFF.
        push(0, 0, 1'b0); push(0, 1, 1'b0); push(0, 2, 1'b0);
        accept(0, 16'h00FF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_out_valid", int'(ov[0]), 0);
        chk("t6_rst_count", cnt[0], 0);
        chk("t6_rst_in_ready", int'(ir[0]), 1);
        chk("t6_rst_out_last", int'(ol[0]), 0);
        rst = 1'b0;
        exp_q[0].delete();
        ordy[0] = 1'b1;
        push(0, 7, 1'b1);
        accept(0, 16'h0080);
        chk("t6_new_count", cnt[0], 1);
        drain(0);

        // Input churn during EMIT, held through the final handshake edge.
        push(0, 0, 1'b0); push(0, 7, 1'b1);
        accept(0, 16'h0081);
        iv[0] = 1'b1; idata[0] = 16'h00FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_no_accept_on_last", int'(ov[0]), 0);
        chk("t6_ready_after_last", int'(ir[0]), 1);
        chk("t6_count_unchanged", cnt[0], 2);
        iv[0] = 1'b0; idata[0] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_still_idle", int'(ov[0]), 0);

        for (int d = 0; d < 3; d++) chk("final_queue_empty", exp_q[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
